// File: rtl/ah_lru_arb_pkg.sv
// ---------------------------------------------------------------------------
// ah_lru_arb_pkg
// Shared definitions for the N-way LRU arbiter:
//   N_MIN / N_MAX : supported requester count range
//   idx_w()       : binary index width for N channels (clog2, never below 1)
//   reset_age()   : age loaded into channel i at reset (channel 0 oldest)
// ---------------------------------------------------------------------------
package ah_lru_arb_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 32;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int reset_age(input int n, input int i);
    return n - 1 - i;
  endfunction

endpackage

// File: rtl/ah_lru_pick.sv
// ---------------------------------------------------------------------------
// ah_lru_pick
// Combinational winner select: the eligible channel holding the largest age.
// Ages are a permutation, so at most one channel can win.
// Ports:
//   elig    in  N     eligible channels
//   ages    in  N*IW  packed ages, channel i at [i*IW +: IW]
//   win     out N     one-hot winner (zero when nothing eligible)
//   win_idx out IW    binary index of winner (zero when nothing eligible)
//   any     out 1     at least one channel eligible
// ---------------------------------------------------------------------------
module ah_lru_pick
  import ah_lru_arb_pkg::*;
#(
  parameter int N  = 7,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]    elig,
  input  logic [N*IW-1:0] ages,
  output logic [N-1:0]    win,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  logic [IW-1:0] best_age;

  always_comb begin
    best_age = '0;
    win_idx  = '0;
    any      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (elig[i] && (!any || (ages[i*IW +: IW] > best_age))) begin
        any      = 1'b1;
        best_age = ages[i*IW +: IW];
        win_idx  = IW'(i);
      end
    end
  end

  assign win = any ? (N'(1) << win_idx) : '0;

endmodule

// File: rtl/ah_lru_arbiter_n.sv
// ---------------------------------------------------------------------------
// ah_lru_arbiter_n
// N-requester least-recently-used arbiter with per-channel busy mask and a
// registered grant / accept handshake. Ages are refreshed only on an accept
// that ends a grant; the next grant is chosen on that same edge.
// Optional feature macro: AH_LRU_ARB_LOCK_EN (adds the lock input; accept
// with lock=1 keeps the current grant without touching the ages).
// Ports:
//   clk      in  1   clock
//   rstn     in  1   asynchronous active-low reset
//   req      in  N   per-channel request (held until accepted)
//   gnt_busy in  N   1 = channel not eligible this cycle
//   accept   in  1   consumer takes the current grant
//   lock     in  1   (AH_LRU_ARB_LOCK_EN only) keep grant across this accept
//   gnt      out N   registered one-hot grant
//   gnt_vld  out 1   gnt holds a valid grant
//   gnt_idx  out IW  binary index of gnt
// ---------------------------------------------------------------------------
module ah_lru_arbiter_n
  import ah_lru_arb_pkg::*;
#(
  parameter  int N  = 7,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  gnt_busy,
  input  logic          accept,
`ifdef AH_LRU_ARB_LOCK_EN
  input  logic          lock,
`endif
  output logic [N-1:0]  gnt,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  if (N < N_MIN || N > N_MAX) begin : g_n_range
    $error("ah_lru_arbiter_n: N out of range");
  end

  typedef logic [IW-1:0] age_t;
  typedef age_t age_vec_t [N];

  age_vec_t        age_q;
  age_vec_t        age_d;
  logic [N*IW-1:0] ages_flat;
  logic [IW-1:0]   gnt_age;

  logic [N-1:0]    elig;
  logic [N-1:0]    pick_elig;
  logic [N-1:0]    win;
  logic [IW-1:0]   win_idx;
  logic            win_any;

  logic            lock_hold;
  logic            gnt_req;
  logic            acc_end;
  logic            hold;

  logic [N-1:0]    gnt_d;
  logic            gnt_vld_d;
  logic [IW-1:0]   gnt_idx_d;

`ifdef AH_LRU_ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  assign elig    = req & ~gnt_busy;
  assign gnt_req = |(req & gnt);
  // An accept ends the grant unless the burst is locked.
  assign acc_end = gnt_vld & accept & ~lock_hold;
  // Busy never revokes an issued grant; only a dropped request does.
  assign hold    = gnt_vld & gnt_req & (~accept | lock_hold);
  // The accepted channel is excluded from the same-edge re-arbitration.
  assign pick_elig = gnt_vld ? (elig & ~gnt) : elig;

  always_comb begin
    ages_flat = '0;
    gnt_age   = '0;
    for (int i = 0; i < N; i++) begin
      ages_flat[i*IW +: IW] = age_q[i];
      if (gnt[i]) gnt_age = gnt_age | age_q[i];
    end
  end

  ah_lru_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .elig    (pick_elig),
    .ages    (ages_flat),
    .win     (win),
    .win_idx (win_idx),
    .any     (win_any)
  );

  always_comb begin
    gnt_d     = '0;
    gnt_vld_d = 1'b0;
    gnt_idx_d = '0;
    if (hold) begin
      gnt_d     = gnt;
      gnt_vld_d = 1'b1;
      gnt_idx_d = gnt_idx;
    end else if (!gnt_vld || acc_end) begin
      gnt_d     = win;
      gnt_vld_d = win_any;
      gnt_idx_d = win_idx;
    end
  end

  // Accepted channel becomes youngest; everything younger than it ages by one,
  // which keeps the ages a permutation of 0..N-1.
  always_comb begin
    age_d = age_q;
    if (acc_end) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i])                 age_d[i] = '0;
        else if (age_q[i] < gnt_age) age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  // ---- register stage: grant ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_idx <= '0;
    end else begin
      gnt     <= gnt_d;
      gnt_vld <= gnt_vld_d;
      gnt_idx <= gnt_idx_d;
    end
  end

  // ---- register stage: ages ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) age_q[i] <= age_t'(reset_age(N, i));
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: tb/tb_ah_lru_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_ah_lru_arbiter_n
// Self-checking bench for ah_lru_arbiter_n (N=7). The reference keeps the
// channels in a recency list (oldest first); a channel's age is its distance
// from the young end of that list.
// ---------------------------------------------------------------------------
module tb_ah_lru_arbiter_n;

  localparam int N = 7;

  logic       clk;
  logic       rstn;
  logic [6:0] req;
  logic [6:0] gnt_busy;
  logic       accept;
  logic       lock_i;
  logic [6:0] gnt;
  logic       gnt_vld;
  logic [2:0] gnt_idx;

  int total;
  int bad;

  ah_lru_arbiter_n #(.N(N)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .gnt_busy (gnt_busy),
    .accept   (accept),
`ifdef AH_LRU_ARB_LOCK_EN
    .lock     (lock_i),
`endif
    .gnt      (gnt),
    .gnt_vld  (gnt_vld),
    .gnt_idx  (gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   q[$];
  logic mvld;
  int   midx;

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < N; i++) q.push_back(i);
    mvld = 1'b0;
    midx = 0;
  endtask

  function automatic int mpick(input logic [6:0] e);
    int w;
    w = -1;
    for (int p = 0; p < q.size(); p++) begin
      if (w < 0 && e[q[p]]) w = q[p];
    end
    return w;
  endfunction

  function automatic int m_age(input int ch);
    int a;
    a = 0;
    for (int p = 0; p < q.size(); p++) if (q[p] == ch) a = N - 1 - p;
    return a;
  endfunction

  task automatic model_step(input logic [6:0] r, input logic [6:0] b,
                            input logic a, input logic l);
    logic [6:0] e;
    int w;
    int pos;
    e = r & ~b;
    if (!mvld) begin
      w    = mpick(e);
      mvld = (w >= 0);
      midx = (w >= 0) ? w : 0;
    end else if (a && !l) begin
      w   = mpick(e & ~(7'(1) << midx));
      pos = 0;
      for (int p = 0; p < q.size(); p++) if (q[p] == midx) pos = p;
      q.delete(pos);
      q.push_back(midx);
      mvld = (w >= 0);
      midx = (w >= 0) ? w : 0;
    end else if (!r[midx]) begin
      mvld = 1'b0;
      midx = 0;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic ev, input logic [2:0] ei);
    logic [6:0] eg;
    eg = ev ? (7'(1) << ei) : 7'd0;
    chk({nm, ".vld"}, 32'(gnt_vld), 32'(ev));
    chk({nm, ".idx"}, 32'(gnt_idx), 32'(ei));
    chk({nm, ".gnt"}, 32'(gnt), 32'(eg));
  endtask

  task automatic chk_ages(input string nm);
    for (int i = 0; i < N; i++) chk(nm, 32'(dut.age_q[i]), 32'(m_age(i)));
  endtask

  task automatic step(input logic [6:0] r, input logic [6:0] b,
                      input logic a, input logic l);
    req      = r;
    gnt_busy = b;
    accept   = a;
    lock_i   = l;
    @(posedge clk);
    model_step(r, b, a, l);
    #1;
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    req      = '0;
    gnt_busy = '0;
    accept   = 1'b0;
    lock_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_out("reset", 1'b0, 3'd0);
    chk_ages("reset.age");
    rstn = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [6:0] r;
    logic [6:0] b;
    logic       a;
    logic       v;
    logic [2:0] i;
  } vec_t;

  vec_t tbl [17];

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    req = '0; gnt_busy = '0; accept = 1'b0; lock_i = 1'b0;

    //             req    busy   acc   vld   idx
    tbl[0]  = '{7'h03, 7'h01, 1'b0, 1'b1, 3'd1};  // busy masks ch0
    tbl[1]  = '{7'h01, 7'h01, 1'b0, 1'b0, 3'd0};  // req[1] dropped: withdraw
    tbl[2]  = '{7'h03, 7'h00, 1'b0, 1'b1, 3'd0};  // ch0 still oldest
    tbl[3]  = '{7'h7F, 7'h7F, 1'b0, 1'b1, 3'd0};  // busy does not revoke
    tbl[4]  = '{7'h7F, 7'h00, 1'b0, 1'b1, 3'd0};
    tbl[5]  = '{7'h7F, 7'h00, 1'b1, 1'b1, 3'd1};  // round of accepts
    tbl[6]  = '{7'h7F, 7'h00, 1'b1, 1'b1, 3'd2};
    tbl[7]  = '{7'h7F, 7'h00, 1'b1, 1'b1, 3'd3};
    tbl[8]  = '{7'h7F, 7'h00, 1'b1, 1'b1, 3'd4};
    tbl[9]  = '{7'h7F, 7'h00, 1'b1, 1'b1, 3'd5};
    tbl[10] = '{7'h7F, 7'h00, 1'b1, 1'b1, 3'd6};
    tbl[11] = '{7'h7F, 7'h00, 1'b1, 1'b1, 3'd0};
    tbl[12] = '{7'h08, 7'h00, 1'b1, 1'b1, 3'd3};  // lone requester ch3
    tbl[13] = '{7'h08, 7'h00, 1'b1, 1'b0, 3'd0};
    tbl[14] = '{7'h08, 7'h00, 1'b1, 1'b1, 3'd3};
    tbl[15] = '{7'h08, 7'h00, 1'b1, 1'b0, 3'd0};
    tbl[16] = '{7'h00, 7'h00, 1'b0, 1'b0, 3'd0};

    do_reset();
    for (int k = 0; k < 17; k++) begin
      step(tbl[k].r, tbl[k].b, tbl[k].a, 1'b0);
      chk_out($sformatf("tbl%0d", k), tbl[k].v, tbl[k].i);
      chk_ages($sformatf("tbl%0d.age", k));
      if (k == 13) chk("tbl.age3_zero", 32'(dut.age_q[3]), 32'd0);
    end

    // ---- asynchronous reset in the middle of a grant ----
    do_reset();
    step(7'h01, 7'h00, 1'b0, 1'b0);
    chk_out("ar.g0", 1'b1, 3'd0);
    step(7'h00, 7'h00, 1'b1, 1'b0);   // ch0 accepted, now youngest
    chk_out("ar.acc", 1'b0, 3'd0);
    step(7'h10, 7'h00, 1'b0, 1'b0);
    chk_out("ar.g4", 1'b1, 3'd4);
    #2;
    rstn = 1'b0;
    #1;
    chk_out("ar.async_clr", 1'b0, 3'd0);
    req = 7'h7F;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    chk_ages("ar.age");
    step(7'h7F, 7'h00, 1'b0, 1'b0);
    chk_out("ar.first", 1'b1, 3'd0);

`ifdef AH_LRU_ARB_LOCK_EN
    // ---- locked burst ----
    do_reset();
    step(7'h7F, 7'h7B, 1'b0, 1'b0);
    chk_out("lk.g2", 1'b1, 3'd2);
    for (int k = 0; k < 3; k++) begin
      step(7'h7F, 7'h00, 1'b1, 1'b1);
      chk_out("lk.hold", 1'b1, 3'd2);
      chk("lk.age2", 32'(dut.age_q[2]), 32'd4);
    end
    step(7'h7F, 7'h00, 1'b1, 1'b0);
    chk_out("lk.end", 1'b1, 3'd0);
    chk("lk.age2_zero", 32'(dut.age_q[2]), 32'd0);
    chk_ages("lk.age");
`endif

    // ---- randomized run against the recency-list model ----
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [6:0] r;
      logic [6:0] b;
      logic       a;
      logic       l;
      r = 7'($urandom);
      b = 7'($urandom) & 7'($urandom);
      a = 1'($urandom_range(0, 1));
`ifdef AH_LRU_ARB_LOCK_EN
      l = ($urandom_range(0, 3) == 0);
`else
      l = 1'b0;
`endif
      step(r, b, a, l);
      chk_out("rnd", mvld, 3'(midx));
      chk("rnd.vld_or", 32'(gnt_vld), 32'(|gnt));
      chk_ages("rnd.age");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
